// File: rtl/lsu_pkg.sv
// lsu_pkg: shared FSM states and RV32I memory access size encodings for the load/store unit.
package lsu_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} lsu_state_t;
    typedef enum logic [2:0] {S_SB = 3'b000, S_SH = 3'b001, S_SW = 3'b010} s_size_t;
    typedef enum logic [2:0] {
        L_LB  = 3'b000,
        L_LH  = 3'b001,
        L_LW  = 3'b010,
        L_LBU = 3'b100,
        L_LHU = 3'b101
    } l_size_t;
endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: combinational legality check, byte enables, store lane replication
// and load shift/extend for the load/store unit.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic        i_is_store,
    input  logic [2:0]  i_s_size,
    input  logic [2:0]  i_l_size,
    input  logic [1:0]  i_off,
    input  logic [31:0] i_wdata,
    input  logic [2:0]  i_ld_size,
    input  logic [1:0]  i_ld_off,
    input  logic [31:0] i_rword,
    output logic        o_legal,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_load
);
    logic [2:0]  w_size;
    logic        w_known;
    logic        w_aligned;
    logic [31:0] w_shift;

    // size[1:0] gives the access width (0 byte, 1 half, 2 word) for every legal encoding
    always_comb begin
        w_size    = i_is_store ? i_s_size : i_l_size;
        w_known   = i_is_store ? (i_s_size inside {S_SB, S_SH, S_SW})
                               : (i_l_size inside {L_LB, L_LH, L_LW, L_LBU, L_LHU});
        w_aligned = (w_size[1:0] == 2'd0) ||
                    (w_size[1:0] == 2'd1 && !i_off[0]) ||
                    (w_size[1:0] == 2'd2 && i_off == 2'd0);
        o_legal   = w_known && w_aligned;
        o_be      = w_size[1] ? 4'b1111 :
                    w_size[0] ? 4'b0011 << {i_off[1], 1'b0} : 4'b0001 << i_off;
        o_wdata   = w_size[1] ? i_wdata :
                    w_size[0] ? {2{i_wdata[15:0]}} : {4{i_wdata[7:0]}};
        w_shift   = i_rword >> {i_ld_off, 3'b000};
        o_load    = (i_ld_size == L_LB)  ? {{24{w_shift[7]}}, w_shift[7:0]} :
                    (i_ld_size == L_LH)  ? {{16{w_shift[15]}}, w_shift[15:0]} :
                    (i_ld_size == L_LW)  ? w_shift :
                    (i_ld_size == L_LBU) ? {24'd0, w_shift[7:0]} :
                    (i_ld_size == L_LHU) ? {16'd0, w_shift[15:0]} : 32'd0;
    end
endmodule

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: RV32I load/store unit driving a word-addressed valid/ready data bus,
// stalling the core while an access is outstanding.
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_mem_write_en,
    input  logic        i_mem_read_en,
    input  logic [2:0]  i_s_type_data,
    input  logic [2:0]  i_l_type_data,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        o_stall,
    output logic [31:0] o_load_data,
    output logic        o_access_err,
    output logic        o_bus_req,
    output logic        o_bus_we,
    output logic [31:0] o_bus_addr,
    output logic [3:0]  o_bus_be,
    output logic [31:0] o_bus_wdata,
    input  logic        i_bus_ready,
    input  logic [31:0] i_bus_rdata
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LIM = CW'(TIMEOUT_CYCLES - 1);

    lsu_state_t  r_state, w_next;
    logic        w_op, w_legal, w_timeout;
    logic [3:0]  w_be;
    logic [31:0] w_wdata, w_load;
    logic        r_we, r_err;
    logic [2:0]  r_size;
    logic [1:0]  r_off;
    logic [3:0]  r_be;
    logic [31:0] r_addr, r_wdata, r_rdata;
    logic [CW-1:0] r_cnt;

    lsu_lane_align u_align (
        .i_is_store (i_mem_write_en),
        .i_s_size   (i_s_type_data),
        .i_l_size   (i_l_type_data),
        .i_off      (i_addr[1:0]),
        .i_wdata    (i_wdata),
        .i_ld_size  (r_size),
        .i_ld_off   (r_off),
        .i_rword    (r_rdata),
        .o_legal    (w_legal),
        .o_be       (w_be),
        .o_wdata    (w_wdata),
        .o_load     (w_load)
    );

    always_ff @(posedge i_clk) r_state <= !i_rst_n ? ST_IDLE : w_next;

    always_comb begin
        w_op      = i_mem_write_en || i_mem_read_en;
        w_timeout = (r_cnt == LIM);
        w_next    = r_state;
        case (r_state)
            ST_IDLE: w_next = w_op ? (w_legal ? ST_BUSY : ST_DONE) : ST_IDLE;
            ST_BUSY: w_next = (i_bus_ready || w_timeout) ? ST_DONE : ST_BUSY;
            default: w_next = ST_IDLE;
        endcase
    end

    // a store takes priority when both enables are high
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_we    <= 1'b0;
            r_err   <= 1'b0;
            r_size  <= 3'd0;
            r_off   <= 2'd0;
            r_be    <= 4'd0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_rdata <= 32'd0;
            r_cnt   <= '0;
        end else if (r_state == ST_IDLE && w_op) begin
            r_we    <= i_mem_write_en;
            r_err   <= !w_legal;
            r_size  <= i_mem_write_en ? i_s_type_data : i_l_type_data;
            r_off   <= i_addr[1:0];
            r_be    <= w_be;
            r_addr  <= {i_addr[31:2], 2'b00};
            r_wdata <= w_wdata;
            r_rdata <= 32'd0;
            r_cnt   <= '0;
        end else if (r_state == ST_BUSY) begin
            if (i_bus_ready && !r_we) r_rdata <= i_bus_rdata;
            if (!i_bus_ready && w_timeout) r_err <= 1'b1;
            r_cnt <= w_timeout ? r_cnt : r_cnt + 1'b1;
        end
    end

    always_comb begin
        o_stall      = (r_state == ST_IDLE && w_op) || r_state == ST_BUSY;
        o_bus_req    = r_state == ST_BUSY;
        o_bus_we     = r_we;
        o_bus_addr   = r_addr;
        o_bus_be     = r_be;
        o_bus_wdata  = r_wdata;
        o_access_err = r_state == ST_DONE && r_err;
        o_load_data  = (r_state == ST_DONE && !r_we && !r_err) ? w_load : 32'd0;
    end
endmodule
